boot_copy_ctrl: RTL and testbench



---
 rtl/boot_copy_pkg.sv | 20 ++
 rtl/boot_copy_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_boot_copy_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_copy_pkg.sv
// boot_copy_pkg
// Shared types and constants for the boot copy engine.
//   state_e     : copy FSM state encoding
//   BE_ALL_ONES : wide all-ones vector, sliced to the byte-enable width
package boot_copy_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_CAP = 3'd2,
    WR     = 3'd3,
    CK_REQ = 3'd4,
    CK_CMP = 3'd5,
    DONE   = 3'd6
  } state_e;

  localparam int BE_MAX_W = 128;
  localparam logic [BE_MAX_W-1:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/boot_copy_ctrl.sv
// boot_copy_ctrl
// Boot-time copy engine: reads len words from the boot ROM starting at
// src_base and writes them to a destination SRAM port starting at dst_base.
// Each word takes RD_REQ -> RD_CAP -> WR; WR waits for dst_gnt_i.
// Optional macro BOOT_COPY_CHECKSUM_EN: after the block, the word at
// src_base+len is read and compared against the running sum of the copied
// words; a mismatch raises err_o (sticky until the next accepted start).
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   start_i                start request (only seen in IDLE)
//   src_base_i/dst_base_i  first source / destination word address
//   len_i                  word count, 0..ROM_WORDS
//   busy_o, done_o, err_o  status
//   rom_*                  ROM initiator port (read-only use)
//   dst_*                  destination write port with grant handshake
module boot_copy_ctrl
  import boot_copy_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ROM_WORDS  = 1024,
  parameter int DST_AW     = 14,
  localparam int RA        = $clog2(ROM_WORDS),
  localparam int BEW       = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [RA-1:0]         src_base_i,
  input  logic [DST_AW-1:0]     dst_base_i,
  input  logic [RA:0]           len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  rom_req_o,
  output logic                  rom_we_o,
  output logic [RA-1:0]         rom_addr_o,
  output logic [DATA_WIDTH-1:0] rom_wdata_o,
  output logic [BEW-1:0]        rom_be_o,
  input  logic [DATA_WIDTH-1:0] rom_rdata_i,
  output logic                  dst_req_o,
  output logic                  dst_we_o,
  output logic [DST_AW-1:0]     dst_addr_o,
  output logic [DATA_WIDTH-1:0] dst_wdata_o,
  output logic [BEW-1:0]        dst_be_o,
  input  logic                  dst_gnt_i
);

  state_e                state_q;
  logic [RA-1:0]         src_q;
  logic [DST_AW-1:0]     dst_q;
  logic [RA:0]           len_q;
  logic [RA:0]           idx_q;
  logic [DATA_WIDTH-1:0] data_q;
`ifdef BOOT_COPY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  err_q;
`endif

  // Plain truncated sums give the address wrap for free.
  logic [RA-1:0]     rd_addr;
  logic [RA-1:0]     ck_addr;
  logic [DST_AW-1:0] wr_addr;
  assign rd_addr = src_q + RA'(idx_q);
  assign ck_addr = src_q + RA'(len_q);
  assign wr_addr = dst_q + DST_AW'(idx_q);

  logic last_word;
  assign last_word = (idx_q == len_q - (RA+1)'(1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
`ifdef BOOT_COPY_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            src_q <= src_base_i;
            dst_q <= dst_base_i;
            len_q <= len_i;
            idx_q <= '0;
`ifdef BOOT_COPY_CHECKSUM_EN
            sum_q <= '0;
            err_q <= 1'b0;
            state_q <= (len_i == '0) ? CK_REQ : RD_REQ;
`else
            state_q <= (len_i == '0) ? DONE : RD_REQ;
`endif
          end
        end
        RD_REQ: state_q <= RD_CAP;
        RD_CAP: begin
          data_q  <= rom_rdata_i;
`ifdef BOOT_COPY_CHECKSUM_EN
          sum_q   <= sum_q + rom_rdata_i;
`endif
          state_q <= WR;
        end
        WR: begin
          if (dst_gnt_i) begin
            if (last_word) begin
`ifdef BOOT_COPY_CHECKSUM_EN
              state_q <= CK_REQ;
`else
              state_q <= DONE;
`endif
            end else begin
              idx_q   <= idx_q + (RA+1)'(1);
              state_q <= RD_REQ;
            end
          end
        end
`ifdef BOOT_COPY_CHECKSUM_EN
        CK_REQ: state_q <= CK_CMP;
        CK_CMP: begin
          err_q   <= (rom_rdata_i != sum_q);
          state_q <= DONE;
        end
`endif
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode from the state; address/data are zero outside their
  // request cycles so the port is quiet in IDLE and right after reset.
  always_comb begin
    rom_req_o   = 1'b0;
    rom_addr_o  = '0;
    dst_req_o   = 1'b0;
    dst_addr_o  = '0;
    dst_wdata_o = '0;
    case (state_q)
      RD_REQ: begin
        rom_req_o  = 1'b1;
        rom_addr_o = rd_addr;
      end
`ifdef BOOT_COPY_CHECKSUM_EN
      CK_REQ: begin
        rom_req_o  = 1'b1;
        rom_addr_o = ck_addr;
      end
`endif
      WR: begin
        dst_req_o   = 1'b1;
        dst_addr_o  = wr_addr;
        dst_wdata_o = data_q;
      end
      default: ;
    endcase
  end

`ifndef BOOT_COPY_CHECKSUM_EN
  logic unused_ck;
  assign unused_ck = ^ck_addr;
`endif

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
`ifdef BOOT_COPY_CHECKSUM_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif
  assign rom_we_o    = 1'b0;
  assign rom_wdata_o = '0;
  assign rom_be_o    = BE_ALL_ONES[BEW-1:0];
  assign dst_we_o    = dst_req_o;
  assign dst_be_o    = BE_ALL_ONES[BEW-1:0];

endmodule

// File: tb/tb_boot_copy_ctrl.sv
`timescale 1ns/1ps
module tb_boot_copy_ctrl;
  import boot_copy_pkg::*;

`ifdef BOOT_COPY_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int CKX = CK ? 2 : 0;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [9:0]  src_base_i = '0;
  logic [13:0] dst_base_i = '0;
  logic [10:0] len_i = '0;
  logic        busy_o, done_o, err_o;
  logic        rom_req_o, rom_we_o;
  logic [9:0]  rom_addr_o;
  logic [31:0] rom_wdata_o;
  logic [3:0]  rom_be_o;
  logic [31:0] rom_rdata_i = '0;
  logic        dst_req_o, dst_we_o;
  logic [13:0] dst_addr_o;
  logic [31:0] dst_wdata_o;
  logic [3:0]  dst_be_o;
  logic        dst_gnt_i = 1'b1;

  boot_copy_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .src_base_i(src_base_i), .dst_base_i(dst_base_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rom_req_o(rom_req_o), .rom_we_o(rom_we_o), .rom_addr_o(rom_addr_o),
    .rom_wdata_o(rom_wdata_o), .rom_be_o(rom_be_o), .rom_rdata_i(rom_rdata_i),
    .dst_req_o(dst_req_o), .dst_we_o(dst_we_o), .dst_addr_o(dst_addr_o),
    .dst_wdata_o(dst_wdata_o), .dst_be_o(dst_be_o), .dst_gnt_i(dst_gnt_i)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] rom [0:1023];
  always @(posedge clk_i) if (rom_req_o) rom_rdata_i <= rom[rom_addr_o];

  typedef struct packed { logic [13:0] addr; logic [31:0] data; } wr_t;
  wr_t         wr_q[$];
  logic [9:0]  rd_q[$];

  int errors = 0;
  int checks = 0;
  bit stall_en = 1'b0;
  bit gnt_block = 1'b0;
  int wr_idx = 0;
  int stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: drives the grant, then checks every ROM read and destination
  // write against the expectation queues. The write head is compared on
  // every request cycle, so a stall also proves address/data stability.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_ni || done_o) begin
        wr_idx = 0;
        stall_cnt = 0;
      end
      if (dst_req_o && stall_en && wr_idx == 2 && stall_cnt < 5) begin
        dst_gnt_i = 1'b0;
        stall_cnt++;
      end else begin
        dst_gnt_i = !gnt_block;
      end
      if (rst_ni) chk("req_excl", 64'(rom_req_o & dst_req_o), 64'd0);
      if (rom_req_o) begin
        if (rd_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL rom_rd_extra: got read at %0h expected none", rom_addr_o);
        end else begin
          chk("rom_addr", 64'(rom_addr_o), 64'(rd_q[0]));
          void'(rd_q.pop_front());
        end
      end
      if (dst_req_o && wr_q.size() > 0) begin
        chk("dst_addr", 64'(dst_addr_o), 64'(wr_q[0].addr));
        chk("dst_data", 64'(dst_wdata_o), 64'(wr_q[0].data));
        chk("dst_we", 64'(dst_we_o), 64'd1);
        if (dst_gnt_i) begin
          void'(wr_q.pop_front());
          wr_idx++;
        end
      end else if (dst_req_o && dst_gnt_i) begin
        errors++; checks++;
        $display("FAIL dst_wr_extra: got write %0h=%0h expected none", dst_addr_o, dst_wdata_o);
      end
    end
  end

  task automatic push_wr(input logic [13:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic run_copy(input logic [9:0] src, input logic [13:0] dst, input logic [10:0] len,
                          input int exp_done, input bit exp_err, input bit poke);
    int done_k, first_rom, first_dst;
    done_k = -1; first_rom = -1; first_dst = -1;
    @(negedge clk_i);
    start_i = 1'b1; src_base_i = src; dst_base_i = dst; len_i = len;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk_i);
      if (k == 1) begin
        start_i = 1'b0;
        chk("busy_t1", 64'(busy_o), 64'd1);
        chk("err_cleared", 64'(err_o), 64'd0);
      end
      if (poke && k == 2) begin
        start_i = 1'b1; src_base_i = 10'd5; dst_base_i = 14'h300; len_i = 11'd1;
      end
      if (poke && k == 3) start_i = 1'b0;
      if (rom_req_o && first_rom < 0) first_rom = k;
      if (dst_req_o && first_dst < 0) first_dst = k;
      if (done_o) begin
        done_k = k;
        chk("busy_in_done", 64'(busy_o), 64'd1);
        chk("err", 64'(err_o), 64'(exp_err));
        break;
      end
    end
    chk("done_cycle", 64'(done_k), 64'(exp_done));
    chk("first_rom", 64'(first_rom), (len != 0 || CK) ? 64'd1 : 64'(-1));
    chk("first_dst", 64'(first_dst), (len != 0) ? 64'd3 : 64'(-1));
    @(negedge clk_i);
    chk("busy_after", 64'(busy_o), 64'd0);
    chk("done_pulse", 64'(done_o), 64'd0);
    chk("wr_left", 64'(wr_q.size()), 64'd0);
    chk("rd_left", 64'(rd_q.size()), 64'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_err"}, 64'(err_o), 64'd0);
    chk({tag, "_romreq"}, 64'(rom_req_o), 64'd0);
    chk({tag, "_romaddr"}, 64'(rom_addr_o), 64'd0);
    chk({tag, "_romwe"}, 64'(rom_we_o), 64'd0);
    chk({tag, "_romwd"}, 64'(rom_wdata_o), 64'd0);
    chk({tag, "_rombe"}, 64'(rom_be_o), 64'hF);
    chk({tag, "_dstreq"}, 64'(dst_req_o), 64'd0);
    chk({tag, "_dstwe"}, 64'(dst_we_o), 64'd0);
    chk({tag, "_dstaddr"}, 64'(dst_addr_o), 64'd0);
    chk({tag, "_dstwd"}, 64'(dst_wdata_o), 64'd0);
    chk({tag, "_dstbe"}, 64'(dst_be_o), 64'hF);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int dones;
    for (int i = 0; i < 1024; i++) rom[i] = 32'd0;
    rom[0] = 32'd1; rom[1] = 32'd2; rom[2] = 32'd3; rom[3] = 32'd4;
    rom[4] = 32'd10;
    rom[1022] = 32'hA; rom[1023] = 32'hB;

    repeat (3) @(negedge clk_i);
    chk_quiet("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Basic 4-word copy, checksum 1+2+3+4 = 10 matches ROM[4].
    for (int i = 0; i < 4; i++) rd_q.push_back(10'(i));
    if (CK) rd_q.push_back(10'd4);
    push_wr(14'h100, 32'd1); push_wr(14'h101, 32'd2);
    push_wr(14'h102, 32'd3); push_wr(14'h103, 32'd4);
    run_copy(10'd0, 14'h100, 11'd4, 13 + CKX, 1'b0, 1'b0);

    // Same copy with a bad checksum word.
    rom[4] = 32'd11;
    for (int i = 0; i < 4; i++) rd_q.push_back(10'(i));
    if (CK) rd_q.push_back(10'd4);
    push_wr(14'h100, 32'd1); push_wr(14'h101, 32'd2);
    push_wr(14'h102, 32'd3); push_wr(14'h103, 32'd4);
    run_copy(10'd0, 14'h100, 11'd4, 13 + CKX, CK, 1'b0);

    // Zero length: no writes; checksum build reads src once (ROM[7]=0 = sum).
    if (CK) rd_q.push_back(10'd7);
    run_copy(10'd7, 14'h050, 11'd0, 1 + CKX, 1'b0, 1'b0);

    // Source and destination wrap; sum 0x18 vs ROM[2]=3 mismatches.
    rd_q.push_back(10'd1022); rd_q.push_back(10'd1023);
    rd_q.push_back(10'd0);    rd_q.push_back(10'd1);
    if (CK) rd_q.push_back(10'd2);
    push_wr(14'h3FFE, 32'hA); push_wr(14'h3FFF, 32'hB);
    push_wr(14'h0000, 32'd1); push_wr(14'h0001, 32'd2);
    run_copy(10'd1022, 14'h3FFE, 11'd4, 13 + CKX, CK, 1'b0);

    // Five stall cycles on word 2.
    rom[4] = 32'd10;
    stall_en = 1'b1;
    for (int i = 0; i < 4; i++) rd_q.push_back(10'(i));
    if (CK) rd_q.push_back(10'd4);
    push_wr(14'h180, 32'd1); push_wr(14'h181, 32'd2);
    push_wr(14'h182, 32'd3); push_wr(14'h183, 32'd4);
    run_copy(10'd0, 14'h180, 11'd4, 18 + CKX, 1'b0, 1'b0);
    stall_en = 1'b0;

    // Start pulsed while busy must be ignored; sum 1+2 = ROM[2].
    rd_q.push_back(10'd0); rd_q.push_back(10'd1);
    if (CK) rd_q.push_back(10'd2);
    push_wr(14'h200, 32'd1); push_wr(14'h201, 32'd2);
    run_copy(10'd0, 14'h200, 11'd2, 7 + CKX, 1'b0, 1'b1);
    repeat (5) @(negedge clk_i);
    chk("poke_idle", 64'(busy_o), 64'd0);

    // Reset while stalled in WR aborts without done.
    gnt_block = 1'b1;
    rd_q.push_back(10'd0);
    @(negedge clk_i);
    start_i = 1'b1; src_base_i = 10'd0; dst_base_i = 14'h100; len_i = 11'd4;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_in_wr", 64'(dst_req_o), 64'd1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk_quiet("abort");
    rst_ni = 1'b1;
    rd_q.delete();
    wr_q.delete();
    dones = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_idle", 64'(busy_o), 64'd0);
    gnt_block = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
